// File: rtl/shift_pkg.sv
// Shared types for the sequential shifter: op encoding, FSM states, op-field width.
// Pure declarations; no timing or flow-control behaviour of its own.
package shift_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROL = 3'b011,
        OP_ROR = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic op_reserved(input logic [OP_W-1:0] op);
        return op > OP_ROR;
    endfunction

    function automatic logic op_rotate(input logic [OP_W-1:0] op);
        return (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One 1-bit shift/rotate step; purely combinational, zero latency, no flow control.
// Reserved ops pass the value through with bit-out 0.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic [OP_W-1:0]  i_op,
    output logic [WIDTH-1:0] o_val,
    output logic             o_bit
);

    always_comb begin
        o_val = i_val;
        o_bit = 1'b0;
        case (i_op)
            OP_SLL: begin
                o_bit = i_val[WIDTH-1];
                o_val = {i_val[WIDTH-2:0], 1'b0};
            end
            OP_SRL: begin
                o_bit = i_val[0];
                o_val = {1'b0, i_val[WIDTH-1:1]};
            end
            OP_SRA: begin
                o_bit = i_val[0];
                o_val = {i_val[WIDTH-1], i_val[WIDTH-1:1]};
            end
            OP_ROL: begin
                o_bit = i_val[WIDTH-1];
                o_val = {i_val[WIDTH-2:0], i_val[WIDTH-1]};
            end
            OP_ROR: begin
                o_bit = i_val[0];
                o_val = {i_val[0], i_val[WIDTH-1:1]};
            end
            default: begin
                o_val = i_val;
                o_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Iterative shifter, one bit per cycle: result valid N+1 cycles after accept (N = effective amount).
// Result held in DONE until out_ready_i; new requests only accepted from IDLE.
module seq_shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [AMT_W-1:0] b_i,
    input  logic [OP_W-1:0]  op_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             op_err_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_val;
    logic [OP_W-1:0]  r_op;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_err;

    logic [31:0]      w_b_ext;
    logic [CNT_W-1:0] w_amt;
    logic [WIDTH-1:0] w_step_val;
    logic             w_step_bit;

    // Shifts saturate at WIDTH so over-range amounts still clear/sign-fill; rotates wrap.
    always_comb begin
        w_b_ext = 32'(b_i);
        w_amt   = '0;
        if (op_reserved(op_i)) begin
            w_amt = '0;
        end else if (op_rotate(op_i)) begin
            w_amt = CNT_W'(w_b_ext % WIDTH);
        end else if (w_b_ext >= WIDTH) begin
            w_amt = CNT_W'(WIDTH);
        end else begin
            w_amt = CNT_W'(w_b_ext);
        end
    end

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_val (r_val),
        .i_op  (r_op),
        .o_val (w_step_val),
        .o_bit (w_step_bit)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid_i) w_state_nxt = (w_amt == '0) ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (r_cnt == CNT_W'(1)) w_state_nxt = ST_DONE;
            ST_DONE:  if (out_ready_i) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_val   <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        r_val   <= a_i;
                        r_op    <= op_i;
                        r_cnt   <= w_amt;
                        r_carry <= 1'b0;
                        r_err   <= op_reserved(op_i);
                    end
                end
                ST_SHIFT: begin
                    r_val   <= w_step_val;
                    r_carry <= w_step_bit;
                    r_cnt   <= r_cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready_o  = (r_state == ST_IDLE);
    assign out_valid_o = (r_state == ST_DONE);
    assign result_o    = r_val;
    assign carry_o     = r_carry;
    assign op_err_o    = r_err;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit (WIDTH=8, AMT_W=8): expected results queued at
// request time from an independent closed-form model, popped when out_valid_o rises.
module tb_seq_shift_unit;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [7:0] a_i;
    logic [7:0] b_i;
    logic [2:0] op_i;
    logic       out_valid_o;
    logic       out_ready_i;
    logic [7:0] result_o;
    logic       carry_o;
    logic       op_err_o;

    typedef struct {
        logic [7:0] res;
        logic       carry;
        logic       err;
        int         n;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    seq_shift_unit #(.WIDTH(8), .AMT_W(8)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .op_i        (op_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .carry_o     (carry_o),
        .op_err_o    (op_err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        exp_t e;
        int   n;
        e.err = 1'b0;
        case (op)
            3'd0, 3'd1, 3'd2: n = (int'(b) >= 8) ? 8 : int'(b);
            3'd3, 3'd4:       n = int'(b) % 8;
            default:          n = 0;
        endcase
        e.n = n;
        case (op)
            3'd0: begin
                e.res   = (n >= 8) ? 8'h00 : (a << n);
                e.carry = (n == 0) ? 1'b0 : a[8-n];
            end
            3'd1: begin
                e.res   = a >> n;
                e.carry = (n == 0) ? 1'b0 : a[n-1];
            end
            3'd2: begin
                e.res   = $signed(a) >>> n;
                e.carry = (n == 0) ? 1'b0 : a[n-1];
            end
            3'd3: begin
                e.res   = (a << n) | (a >> (8 - n));
                e.carry = (n == 0) ? 1'b0 : a[8-n];
            end
            3'd4: begin
                e.res   = (a >> n) | (a << (8 - n));
                e.carry = (n == 0) ? 1'b0 : a[n-1];
            end
            default: begin
                e.res   = a;
                e.carry = 1'b0;
                e.err   = 1'b1;
            end
        endcase
        return e;
    endfunction

    // Issue one request, check latency and result, optionally stall in DONE, then consume.
    task automatic do_req(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op, input int hold, input bit keep_valid);
        exp_t e;
        int   k;
        sb.push_back(model(a, b, op));
        k = 0;
        while (in_ready_o !== 1'b1 && k < 20) begin
            @(posedge clk_i); #1; k++;
        end
        in_valid_i = 1'b1; a_i = a; b_i = b; op_i = op;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        a_i = 8'($urandom); b_i = 8'($urandom); op_i = 3'($urandom_range(0, 7));
        k = 0;
        while (out_valid_o !== 1'b1 && k < 40) begin
            @(posedge clk_i); #1; k++;
        end
        e = sb.pop_front();
        n_checks++;
        if (k !== e.n) begin
            n_fail++;
            $display("FAIL %s latency: got %0d edges (out_valid=%b), want %0d", name, k, out_valid_o, e.n);
        end
        n_checks++;
        if (result_o !== e.res) begin
            n_fail++;
            $display("FAIL %s result: got %h want %h", name, result_o, e.res);
        end
        n_checks++;
        if (carry_o !== e.carry) begin
            n_fail++;
            $display("FAIL %s carry: got %b want %b", name, carry_o, e.carry);
        end
        n_checks++;
        if (op_err_o !== e.err) begin
            n_fail++;
            $display("FAIL %s op_err: got %b want %b", name, op_err_o, e.err);
        end
        if (keep_valid) begin
            in_valid_i = 1'b1; a_i = 8'h5A; b_i = 8'd3; op_i = 3'd0;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i); #1;
            n_checks++;
            if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 || result_o !== e.res ||
                carry_o !== e.carry || op_err_o !== e.err) begin
                n_fail++;
                $display("FAIL %s hold[%0d]: got v=%b rdy=%b res=%h c=%b err=%b want v=1 rdy=0 res=%h c=%b err=%b",
                         name, i, out_valid_o, in_ready_o, result_o, carry_o, op_err_o, e.res, e.carry, e.err);
            end
        end
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        n_checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s consume: got rdy=%b v=%b want rdy=1 v=0", name, in_ready_o, out_valid_o);
        end
        in_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        a_i = 8'h00; b_i = 8'h00; op_i = 3'd0;
        repeat (3) @(posedge clk_i);
        #1;
        n_checks++;
        if (out_valid_o !== 1'b0 || result_o !== 8'h00 || carry_o !== 1'b0 || op_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset outputs: got v=%b res=%h c=%b err=%b want 0/00/0/0",
                     out_valid_o, result_o, carry_o, op_err_o);
        end
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        n_checks++;
        if (in_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset in_ready: got %b want 1", in_ready_o);
        end
    endtask

    task automatic test_ops();
        do_req("sll_d3_3", 8'hD3, 8'd3, 3'd0, 0, 1'b0);
        do_req("srl_d3_3", 8'hD3, 8'd3, 3'd1, 0, 1'b0);
        do_req("sra_d3_3", 8'hD3, 8'd3, 3'd2, 0, 1'b0);
        do_req("rol_d3_3", 8'hD3, 8'd3, 3'd3, 0, 1'b0);
        do_req("ror_d3_3", 8'hD3, 8'd3, 3'd4, 0, 1'b0);
    endtask

    task automatic test_wide_amounts();
        do_req("srl_d3_108", 8'hD3, 8'd108, 3'd1, 0, 1'b0);
        do_req("rol_d3_108", 8'hD3, 8'd108, 3'd3, 0, 1'b0);
        do_req("sll_d3_8",   8'hD3, 8'd8,   3'd0, 0, 1'b0);
        do_req("sra_93_200", 8'h93, 8'd200, 3'd2, 0, 1'b0);
        do_req("sra_53_9",   8'h53, 8'd9,   3'd2, 0, 1'b0);
        do_req("ror_d3_16",  8'hD3, 8'd16,  3'd4, 0, 1'b0);
        do_req("sll_d3_0",   8'hD3, 8'd0,   3'd0, 0, 1'b0);
    endtask

    task automatic test_reserved();
        do_req("rsv_110", 8'hD3, 8'd0, 3'd6, 0, 1'b0);
        do_req("rsv_101", 8'hA5, 8'd4, 3'd5, 1, 1'b0);
    endtask

    task automatic test_backpressure();
        do_req("bp_ror", 8'h3C, 8'd5, 3'd4, 5, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            do_req("b2b", 8'($urandom), 8'($urandom_range(0, 12)), 3'($urandom_range(0, 7)),
                   int'($urandom_range(0, 2)), 1'b0);
        end
    endtask

    task automatic test_reset_mid_shift();
        int k;
        k = 0;
        while (in_ready_o !== 1'b1 && k < 20) begin
            @(posedge clk_i); #1; k++;
        end
        in_valid_i = 1'b1; a_i = 8'hD3; b_i = 8'd5; op_i = 3'd0;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        n_checks++;
        if (out_valid_o !== 1'b0 || result_o !== 8'h00 || carry_o !== 1'b0 || op_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst outputs: got v=%b res=%h c=%b err=%b want 0/00/0/0",
                     out_valid_o, result_o, carry_o, op_err_o);
        end
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        n_checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst release: got rdy=%b v=%b want rdy=1 v=0", in_ready_o, out_valid_o);
        end
        do_req("after_rst", 8'hD3, 8'd2, 3'd1, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_ops();
        test_wide_amounts();
        test_reserved();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_shift_unit.md
SEQ_SHIFT_UNIT -- requirements
Module: seq_shift_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal values: 2 or greater).
REQ-002 The block SHALL have parameter AMT_W, default 8, giving the shift-amount width in bits.
REQ-003 clk_i  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst_ni  input  1  reset, synchronous and active-low.
REQ-005 in_valid_i  input  1  request valid.
REQ-006 in_ready_o  output  1  unit can accept a request.
REQ-007 a_i  input  WIDTH  operand to shift.
REQ-008 b_i  input  AMT_W  shift amount, unsigned.
REQ-009 op_i  input  3  operation select: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101-111 reserved.
REQ-010 out_valid_o  output  1  result valid.
REQ-011 out_ready_i  input  1  consumer accepts the result.
REQ-012 result_o  output  WIDTH  shifted result.
REQ-013 carry_o  output  1  last bit shifted or rotated out; 0 when the effective amount is 0.
REQ-014 op_err_o  output  1  the request used a reserved op; valid together with out_valid_o.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT and DONE; in_ready_o SHALL be 1 only in IDLE.
REQ-016 The unit SHALL accept a request on an edge where in_valid_i and in_ready_o are both 1, and SHALL then capture a_i, op_i and the effective amount N.
REQ-017 N SHALL be min(b_i, WIDTH) for SLL, SRL and SRA, and b_i mod WIDTH for ROL and ROR.
REQ-018 On accept, the FSM SHALL go IDLE->SHIFT if N>0, else IDLE->DONE.
REQ-019 SHIFT SHALL perform exactly one 1-bit step per cycle and SHALL go to DONE after the Nth step.
REQ-020 Step fill SHALL be: zero for SLL and SRL; the current MSB for SRA; the outgoing bit for ROL and ROR.
REQ-021 Latency: if accept occurs at edge T, out_valid_o SHALL first be 1 in the cycle after edge T+N.
REQ-022 In DONE, out_valid_o SHALL be 1, and result_o, carry_o and op_err_o SHALL be held stable until an edge with out_ready_i=1; that edge SHALL move the FSM to IDLE.
REQ-023 No new request SHALL be accepted in the same cycle a result is consumed; the minimum spacing between accepts is N+2 cycles.
REQ-024 A reserved op SHALL force N=0, result_o=a, carry_o=0 and op_err_o=1.
REQ-025 SLL or SRL with b_i>=WIDTH SHALL give result 0; SRA with b_i>=WIDTH SHALL give all bits equal to the sign bit; carry_o SHALL be the bit removed at step N.
REQ-026 Input changes while not in IDLE SHALL have no effect on the operation in flight.

Reset
REQ-027 Reset asserted on any edge, including mid-SHIFT or in DONE, SHALL force IDLE and discard any operation in flight.
REQ-028 Reset values SHALL be: in_ready_o=1 after release, out_valid_o=0, result_o=0, carry_o=0, op_err_o=0, and the internal counter at 0.

Structure
REQ-029 Package shift_pkg SHALL hold the op enum (SLL, SRL, SRA, ROL, ROR), the FSM state enum and the op width constant 3.
REQ-030 A combinational sub-module shift_step SHALL perform one 1-bit step (inputs: value and op; outputs: next value and bit out) and SHALL be instantiated once.
REQ-031 The counter width SHALL be $clog2(WIDTH+1).

Verification (WIDTH=8, AMT_W=8)
REQ-032 Scenario: a=0xD3, b=3, SLL -> result 0x98, carry 0, out_valid_o first high 4 cycles after accept.
REQ-033 Scenario: a=0xD3, b=3, SRA -> result 0xFA, carry 0; a=0xD3, b=3, ROR -> result 0x7A, carry 0.
REQ-034 Scenario: a=0xD3, b=0x6C (108), SRL -> result 0x00, carry 1, 8 shift cycles; same operands with ROL -> N=4, result 0x3D.
REQ-035 Scenario: b=0 and op 110 -> out_valid_o 1 cycle after accept, result 0xD3, op_err_o 1, carry 0.
REQ-036 Scenario: hold out_ready_i=0 for 5 cycles in DONE -> outputs stable, in_ready_o 0; then out_ready_i=1 -> IDLE on the next edge.
REQ-037 Scenario: assert rst_ni=0 in the 2nd SHIFT cycle -> next cycle out_valid_o 0 and all outputs at their reset values; in_ready_o 1 once reset is released.
